serial_signed_sub_with_overflow: RTL and testbench

- Bit-serial two's-complement subtractor: diff = a - b, processed one bit per clock, LSB first, with a signed overflow flag.
- It is the inverse-direction arithmetic companion to the team's combinational signed adder-with-overflow.
- Used where area matters more than latency.
- Operands enter through a valid/ready upstream port. Result and flag leave through a valid/ready downstream port.

---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/serial_signed_sub_with_overflow_full_sub_bit.sv | 20 ++
 rtl/serial_signed_sub_with_overflow.sv | 159 +++++++++++++++
 tb/tb_serial_signed_sub_with_overflow.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial signed subtractor.
//   state_t  : controller states (IDLE / SHIFT / HOLD), 2-bit encoding
//   ovf_sub  : signed-overflow rule for diff = a - b, given operand and result signs
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // a - b can only overflow when the operands have different signs, and it
  // has overflowed when the result sign differs from the minuend's sign.
  function automatic logic ovf_sub(input logic sign_a, input logic sign_b, input logic sign_d);
    return (sign_a != sign_b) && (sign_d != sign_a);
  endfunction

endpackage

// File: rtl/serial_signed_sub_with_overflow_full_sub_bit.sv
// One-bit adder cell used as the subtractor slice: the subtrahend bit arrives
// already inverted (y_n) and the initial carry supplies the +1, so a plain
// full-add of x + y_n + cin yields one bit of a - b.
//   x    : minuend bit
//   y_n  : inverted subtrahend bit
//   cin  : carry in
//   s    : sum bit
//   cout : carry out (majority of the three inputs)
module full_sub_bit (
  input  logic x,
  input  logic y_n,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y_n ^ cin;
  assign cout = (x & y_n) | (x & cin) | (y_n & cin);

endmodule

// File: rtl/serial_signed_sub_with_overflow.sv
// Bit-serial two's-complement subtractor, diff = a - b, one bit per clock,
// LSB first, with a registered signed-overflow flag.
//   clk, rst_n             : clock, asynchronous active-low reset
//   up_valid / up_ready    : operand handshake (a, b sampled on acceptance)
//   a, b                   : signed minuend / subtrahend, W bits
//   down_valid / down_ready: result handshake
//   diff                   : a - b modulo 2^W, updated only when entering HOLD
//   overflow               : true result outside the signed W-bit range
module serial_signed_sub_with_overflow
  import serial_sub_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         down_valid,
  input  logic         down_ready,
  output logic [W-1:0] diff,
  output logic         overflow
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic          r_up_ready;
  logic          r_down_valid;
  logic [W-1:0]  r_ra;
  logic [W-1:0]  r_rb;
  logic [W-1:0]  r_res;
  logic [W-1:0]  r_diff;
  logic          r_ovf;
  logic          r_carry;
  logic          r_sign_a;
  logic          r_sign_b;
  logic [CW-1:0] r_cnt;

  logic          w_s;
  logic          w_cout;
  logic [W-1:0]  w_res_next;
  logic          w_last;

  full_sub_bit u_cell (
    .x    (r_ra[0]),
    .y_n  (r_rb[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // The new bit enters at the MSB, so after W shifts the LSB sits at bit 0.
  assign w_res_next = {w_s, r_res[W-1:1]};
  assign w_last     = (r_cnt == CNT_LAST);

  // Next-state logic for the IDLE -> SHIFT -> HOLD controller.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (up_valid) begin
          w_next_state = SHIFT;
        end else begin
          w_next_state = IDLE;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_next_state = HOLD;
        end else begin
          w_next_state = SHIFT;
        end
      end
      HOLD: begin
        if (down_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = HOLD;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State register plus handshake outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_up_ready   <= 1'b1;
      r_down_valid <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_up_ready   <= (w_next_state == IDLE);
      r_down_valid <= (w_next_state == HOLD);
    end
  end

  // Datapath: operand capture, serial shifting, and result/flag publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ra     <= '0;
      r_rb     <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_ovf    <= 1'b0;
      r_carry  <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (up_valid) begin
            r_ra     <= a;
            r_rb     <= ~b;
            r_carry  <= 1'b1;
            r_sign_a <= a[W-1];
            r_sign_b <= b[W-1];
            r_cnt    <= '0;
          end else begin
            r_cnt    <= r_cnt;
          end
        end
        SHIFT: begin
          r_ra    <= {1'b0, r_ra[W-1:1]};
          r_rb    <= {1'b0, r_rb[W-1:1]};
          r_carry <= w_cout;
          r_res   <= w_res_next;
          r_cnt   <= r_cnt + CW'(1);
          // Publish only on the final bit so diff never shows partial results.
          if (w_last) begin
            r_diff <= w_res_next;
            r_ovf  <= ovf_sub(r_sign_a, r_sign_b, w_s);
          end else begin
            r_diff <= r_diff;
          end
        end
        HOLD: begin
          r_diff <= r_diff;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign up_ready   = r_up_ready;
  assign down_valid = r_down_valid;
  assign diff       = r_diff;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_serial_signed_sub_with_overflow.sv
// Self-checking bench for serial_signed_sub_with_overflow (W = 4).
module tb_serial_signed_sub_with_overflow;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up_valid;
  logic       up_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       down_valid;
  logic       down_ready;
  logic [3:0] diff;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  serial_signed_sub_with_overflow #(.W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .a          (a),
    .b          (b),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .diff       (diff),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Reference: true integer difference, wrapped to 4 bits, range-checked.
  function automatic void ref_sub(input logic [3:0] ia, input logic [3:0] ib,
                                  output logic [3:0] d, output logic o);
    int t;
    t = int'($signed(ia)) - int'($signed(ib));
    d = t[3:0];
    o = (t > 7) || (t < -8);
  endfunction

  // Drives one operand pair, waits for the result, then accepts it at once.
  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib,
                        output logic [3:0] d, output logic o,
                        output int lat, output bit to);
    int w;
    to = 1'b0; lat = 0; d = 4'd0; o = 1'b0;
    @(negedge clk);
    w = 0;
    while (!up_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!up_ready) begin
      to = 1'b1;
      return;
    end
    a = ia; b = ib; up_valid = 1'b1;
    @(posedge clk);
    #1 up_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (down_valid) break;
      if (lat > 20) begin
        to = 1'b1;
        return;
      end
      @(posedge clk);
      lat++;
    end
    d = diff; o = overflow;
    down_ready = 1'b1;
    @(posedge clk);
    #1 down_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (up_ready !== 1'b1 || down_valid !== 1'b0 || diff !== 4'd0 || overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: up_ready=%b down_valid=%b diff=%h ovf=%b, required 1 0 0 0",
               up_ready, down_valid, diff, overflow);
    end
  endtask

  task automatic test_basic();
    int va [7] = '{3, -3, 0, -8, 0, -8, -1};
    int vb [7] = '{-5, 5, 0, 1, -8, -8, -1};
    int ed [7] = '{-8, -8, 0, 7, -8, 0, 0};
    bit eo [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] d;
    logic o;
    int lat;
    bit to;
    for (int i = 0; i < 7; i++) begin
      run_op(4'(va[i]), 4'(vb[i]), d, o, lat, to);
      n_cmp++;
      if (to || lat !== 4 || d !== 4'(ed[i]) || o !== eo[i]) begin
        n_bad++;
        $display("FAIL basic[%0d] a=%0d b=%0d: diff=%h ovf=%b lat=%0d timeout=%b, required diff=%h ovf=%b lat=4",
                 i, va[i], vb[i], d, o, lat, to, 4'(ed[i]), eo[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] ra, rb, d, ed;
    logic o, eo;
    int lat;
    bit to;
    for (int i = 0; i < 20; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      ref_sub(ra, rb, ed, eo);
      run_op(ra, rb, d, o, lat, to);
      n_cmp++;
      if (to || lat !== 4 || d !== ed || o !== eo) begin
        n_bad++;
        $display("FAIL random a=%h b=%h: diff=%h ovf=%b lat=%0d, required diff=%h ovf=%b lat=4",
                 ra, rb, d, o, lat, ed, eo);
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    @(negedge clk);
    a = 4'd6; b = 4'd2; up_valid = 1'b1;
    @(posedge clk);
    #1 up_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (!down_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (w !== 4) begin
      n_bad++;
      $display("FAIL bp_latency: %0d cycles, required 4", w);
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (down_valid !== 1'b1 || up_ready !== 1'b0 || diff !== 4'd4 || overflow !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: dv=%b ur=%b diff=%h ovf=%b, required 1 0 4 0",
                 i, down_valid, up_ready, diff, overflow);
      end
      @(negedge clk);
    end
    down_ready = 1'b1;
    @(posedge clk);
    #1 down_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (up_ready !== 1'b1 || down_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: up_ready=%b down_valid=%b, required 1 0", up_ready, down_valid);
    end
  endtask

  task automatic test_input_stability();
    logic [3:0] na, nb, ed, d;
    logic eo, o;
    int w;
    @(negedge clk);
    a = 4'd5; b = 4'hD; up_valid = 1'b1;
    @(posedge clk);
    #1;
    w = 0;
    forever begin
      @(negedge clk);
      if (down_valid || w > 20) break;
      n_cmp++;
      if (up_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stab_ready[%0d]: up_ready=%b, required 0", w, up_ready);
      end
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      w++;
    end
    n_cmp++;
    if (w !== 4 || diff !== 4'h8 || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL stab_first: diff=%h ovf=%b lat=%0d, required diff=8 ovf=1 lat=4", diff, overflow, w);
    end
    na = 4'($urandom_range(0, 15));
    nb = 4'($urandom_range(0, 15));
    ref_sub(na, nb, ed, eo);
    a = na; b = nb;
    down_ready = 1'b1;
    @(posedge clk);
    #1 down_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (up_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL stab_idle: up_ready=%b, required 1", up_ready);
    end
    @(posedge clk);
    #1 up_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (!down_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    d = diff; o = overflow;
    n_cmp++;
    if (w !== 4 || d !== ed || o !== eo) begin
      n_bad++;
      $display("FAIL stab_second a=%h b=%h: diff=%h ovf=%b lat=%0d, required diff=%h ovf=%b lat=4",
               na, nb, d, o, w, ed, eo);
    end
    down_ready = 1'b1;
    @(posedge clk);
    #1 down_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [3:0] d;
    logic o;
    int lat;
    bit to;
    run_op(4'd7, 4'd1, d, o, lat, to);
    @(negedge clk);
    a = 4'd1; b = 4'd6; up_valid = 1'b1;
    @(posedge clk);
    #1 up_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (down_valid !== 1'b0 || diff !== 4'd0 || overflow !== 1'b0 || up_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_clear: dv=%b diff=%h ovf=%b ur=%b, required 0 0 0 1",
               down_valid, diff, overflow, up_ready);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(4'd2, 4'd3, d, o, lat, to);
    n_cmp++;
    if (to || lat !== 4 || d !== 4'hF || o !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_after: diff=%h ovf=%b lat=%0d, required diff=f ovf=0 lat=4", d, o, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] q_d [$];
    logic       q_o [$];
    logic [3:0] ed, ea, eb;
    logic       eo, dr;
    int idx = 0;
    int got = 0;
    int cyc = 0;
    while (got < 256 && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      dr = ($urandom_range(0, 2) != 0);
      down_ready = dr;
      if (down_valid && dr) begin
        n_cmp++;
        if (q_d.size() == 0) begin
          n_bad++;
          $display("FAIL sweep_extra: unexpected result diff=%h ovf=%b", diff, overflow);
        end else begin
          ed = q_d.pop_front();
          eo = q_o.pop_front();
          got++;
          if (diff !== ed || overflow !== eo) begin
            n_bad++;
            $display("FAIL sweep[%0d]: diff=%h ovf=%b, required diff=%h ovf=%b",
                     got - 1, diff, overflow, ed, eo);
          end
        end
      end
      if (idx < 256) begin
        ea = idx[7:4];
        eb = idx[3:0];
        a = ea; b = eb; up_valid = 1'b1;
        if (up_ready) begin
          ref_sub(ea, eb, ed, eo);
          q_d.push_back(ed);
          q_o.push_back(eo);
          idx++;
        end
      end else begin
        up_valid = 1'b0;
      end
    end
    n_cmp++;
    if (got !== 256) begin
      n_bad++;
      $display("FAIL sweep_count: %0d results, required 256", got);
    end
    @(negedge clk);
    up_valid = 1'b0;
    down_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; up_valid = 1'b0; down_ready = 1'b0; a = 4'd0; b = 4'd0;
    #12 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_random();
    test_backpressure();
    test_input_stability();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
